// File: rtl/me_pkg.sv
// Shared motion-estimator definitions: search FSM states and default geometry.
package me_pkg;

  localparam int unsigned DefaultDistW = 8;
  localparam int unsigned DefaultNumX  = 16;
  localparam int unsigned DefaultNumY  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StDone
  } me_state_e;

endpackage

// File: rtl/search_pos_counter.sv
// Raster-order candidate position counter (x fastest, then y) with clear, enable
// and a flag marking the last position of the search window.
module search_pos_counter #(
  parameter int unsigned NumX = 16,
  parameter int unsigned NumY = 16,
  parameter int unsigned XW   = $clog2(NumX),
  parameter int unsigned YW   = $clog2(NumY)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          en_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          last_o
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          last_x, last_y;

  assign last_x = (x_q == XW'(NumX - 1));
  assign last_y = (y_q == YW'(NumY - 1));

  // Next position: clear wins over advance; the window wraps back to (0,0).
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (en_i) begin
      if (last_x) begin
        x_d = '0;
        y_d = last_y ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = last_x & last_y;

endmodule

// File: rtl/sad_min_select.sv
// Tracks the minimum distortion over one search window and reports it with the
// motion vector of the earliest candidate achieving it, plus a one-cycle done.
module sad_min_select
  import me_pkg::*;
#(
  parameter int unsigned DIST_W = DefaultDistW,
  parameter int unsigned NUM_X  = DefaultNumX,
  parameter int unsigned NUM_Y  = DefaultNumY,
  parameter int unsigned X_W    = $clog2(NUM_X),
  parameter int unsigned Y_W    = $clog2(NUM_Y)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              dist_valid,
  input  logic [DIST_W-1:0] dist_in,
  output logic [DIST_W-1:0] best_dist,
  output logic [X_W-1:0]    motion_x,
  output logic [Y_W-1:0]    motion_y,
  output logic              busy,
  output logic              done
);

  me_state_e         state_q, state_d;
  logic              first_q, first_d;
  logic [DIST_W-1:0] best_q, best_d;
  logic [X_W-1:0]    mx_q, mx_d;
  logic [Y_W-1:0]    my_q, my_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [X_W-1:0]    cand_x;
  logic [Y_W-1:0]    cand_y;
  logic              cand_last;
  logic              accept;
  logic              take;

  // A start cycle discards the sample so an abort restarts cleanly at (0,0).
  assign accept = (state_q == StSearch) & dist_valid & ~start;
  // Strict compare keeps the earlier candidate on ties.
  assign take   = accept & (first_q | (dist_in < best_q));

  search_pos_counter #(
    .NumX (NUM_X),
    .NumY (NUM_Y),
    .XW   (X_W),
    .YW   (Y_W)
  ) u_pos (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .clear_i (start),
    .en_i    (accept),
    .x_o     (cand_x),
    .y_o     (cand_y),
    .last_o  (cand_last)
  );

  // Next-state and next-output logic for the search FSM.
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    best_d  = best_q;
    mx_d    = mx_q;
    my_d    = my_q;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StSearch;
      end
      StSearch: begin
        if (!start && accept && cand_last) state_d = StDone;
      end
      StDone: begin
        state_d = start ? StSearch : StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      first_d = 1'b1;
    end else if (accept) begin
      first_d = 1'b0;
    end

    if (take) begin
      best_d = dist_in;
      mx_d   = cand_x;
      my_d   = cand_y;
    end

    busy_d = (state_d == StSearch);
    done_d = (state_d == StDone);
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      first_q <= 1'b1;
      best_q  <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      best_q  <= best_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign best_dist = best_q;
  assign motion_x  = mx_q;
  assign motion_y  = my_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sad_min_select.sv
// Directed/randomised bench for sad_min_select with an array-based minimum model.
module tb_sad_min_select;

  localparam int unsigned DistW = 8;
  localparam int unsigned NumX  = 16;
  localparam int unsigned NumY  = 16;
  localparam int unsigned NCand = NumX * NumY;

  logic             clock;
  logic             reset_n;
  logic             start;
  logic             dist_valid;
  logic [DistW-1:0] dist_in;
  logic [DistW-1:0] best_dist;
  logic [3:0]       motion_x;
  logic [3:0]       motion_y;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;
  int cand [NCand];
  bit early_done;
  bit busy_lost;

  sad_min_select #(
    .DIST_W (DistW),
    .NUM_X  (NumX),
    .NUM_Y  (NumY)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .dist_valid (dist_valid),
    .dist_in    (dist_in),
    .best_dist  (best_dist),
    .motion_x   (motion_x),
    .motion_y   (motion_y),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Earliest index holding the smallest value among the first n candidates.
  task automatic ref_min(input int n, output int best, output int idx);
    best = cand[0];
    idx  = 0;
    for (int i = 1; i < n; i++) begin
      if (cand[i] < best) begin
        best = cand[i];
        idx  = i;
      end
    end
  endtask

  task automatic do_start();
    start      = 1'b1;
    dist_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  // Presents cand[0..n-1]; with stall set, random idle gaps precede each value.
  task automatic feed(input int n, input bit stall);
    early_done = 1'b0;
    busy_lost  = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (stall) begin
        for (int k = 0; k < 8 && $urandom_range(0, 1) == 1; k++) begin
          dist_valid = 1'b0;
          dist_in    = DistW'($urandom);
          tick();
          if (done) early_done = 1'b1;
          if (!busy) busy_lost = 1'b1;
        end
      end
      dist_valid = 1'b1;
      dist_in    = DistW'(cand[i]);
      tick();
      if (i < n - 1) begin
        if (done) early_done = 1'b1;
        if (!busy) busy_lost = 1'b1;
      end
    end
    dist_valid = 1'b0;
  endtask

  // Called in the cycle right after the last candidate was accepted.
  task automatic check_result(input string tag);
    int best, idx;
    ref_min(NCand, best, idx);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    check({tag, ".no_early_done"}, 32'(early_done), 32'd0);
    check({tag, ".busy_during"}, 32'(busy_lost), 32'd0);
    check({tag, ".best"}, 32'(best_dist), 32'(best));
    check({tag, ".mx"}, 32'(motion_x), 32'(idx % NumX));
    check({tag, ".my"}, 32'(motion_y), 32'(idx / NumX));
  endtask

  task automatic full_search(input string tag, input bit stall);
    do_start();
    feed(NCand, stall);
    check_result(tag);
    tick();
    check({tag, ".done_one_cycle"}, 32'(done), 32'd0);
    check({tag, ".best_held"}, 32'(best_dist), 32'(cand[0] < 0 ? 0 : best_dist_exp()));
  endtask

  function automatic int best_dist_exp();
    int b = cand[0];
    for (int i = 1; i < NCand; i++) if (cand[i] < b) b = cand[i];
    return b;
  endfunction

  initial begin
    int best, idx;
    reset_n    = 1'b0;
    start      = 1'b0;
    dist_valid = 1'b0;
    dist_in    = '0;
    #12;
    check("rst.best", 32'(best_dist), 32'd0);
    check("rst.mx", 32'(motion_x), 32'd0);
    check("rst.my", 32'(motion_y), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    reset_n = 1'b1;
    tick();

    // Idle ignores dist_valid.
    dist_valid = 1'b1;
    dist_in    = 8'd3;
    repeat (3) tick();
    dist_valid = 1'b0;
    check("idle.busy", 32'(busy), 32'd0);
    check("idle.best", 32'(best_dist), 32'd0);

    // Reset in the middle of a search.
    for (int i = 0; i < NCand; i++) cand[i] = int'($urandom_range(50, 200));
    do_start();
    feed(10, 1'b0);
    ref_min(10, best, idx);
    check("mid.busy", 32'(busy), 32'd1);
    check("mid.best", 32'(best_dist), 32'(best));
    check("mid.mx", 32'(motion_x), 32'(idx % NumX));
    #3;
    reset_n = 1'b0;
    #1;
    check("arst.best", 32'(best_dist), 32'd0);
    check("arst.mx", 32'(motion_x), 32'd0);
    check("arst.my", 32'(motion_y), 32'd0);
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.done", 32'(done), 32'd0);
    tick();
    reset_n = 1'b1;
    dist_valid = 1'b1;
    repeat (3) tick();
    dist_valid = 1'b0;
    check("arst.idle_busy", 32'(busy), 32'd0);
    check("arst.idle_done", 32'(done), 32'd0);

    // Monotonically decreasing distortion: last candidate wins.
    for (int i = 0; i < NCand; i++) cand[i] = 255 - i;
    full_search("mono", 1'b0);

    // Same values with stalls.
    full_search("stall", 1'b1);

    // All ones: the first candidate must still be captured.
    for (int i = 0; i < NCand; i++) cand[i] = 255;
    full_search("ones", 1'b0);

    // Ties keep the earlier candidate.
    cand[37]  = 4;
    cand[200] = 4;
    full_search("tie", 1'b0);

    // Random windows with stalls.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NCand; i++) cand[i] = int'($urandom_range(0, 255));
      full_search($sformatf("rand%0d", r), 1'b1);
    end

    // Abort: partial search holding a small value, restarted with a valid
    // (discarded) sample on the start cycle.
    for (int i = 0; i < NCand; i++) cand[i] = int'($urandom_range(20, 255));
    cand[3] = 1;
    do_start();
    feed(20, 1'b0);
    start      = 1'b1;
    dist_valid = 1'b1;
    dist_in    = 8'd0;
    tick();
    start      = 1'b0;
    dist_valid = 1'b0;
    check("abort.busy", 32'(busy), 32'd1);
    for (int i = 0; i < NCand; i++) cand[i] = int'($urandom_range(11, 255));
    cand[100] = 10;
    feed(NCand, 1'b0);
    check_result("abort");
    tick();

    // Back-to-back: start issued in the done cycle.
    for (int i = 0; i < NCand; i++) cand[i] = int'($urandom_range(1, 255));
    cand[7] = 0;
    do_start();
    feed(NCand, 1'b0);
    check_result("b2b_first");
    start = 1'b1;
    #2;
    check("b2b.done_during_start", 32'(done), 32'd1);
    tick();
    start = 1'b0;
    check("b2b.done_drop", 32'(done), 32'd0);
    check("b2b.busy_next", 32'(busy), 32'd1);
    for (int i = 0; i < NCand; i++) cand[i] = int'($urandom_range(1, 255));
    feed(NCand, 1'b1);
    check_result("b2b_second");
    tick();
    check("b2b.idle_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
